cdb_arbiter: RTL

// Shares the single common data bus (CDB) between the execution-queue result producers: integer, mult, div and load/store.

---
 rtl/cdb_arbiter_pkg.sv | 27 ++
 rtl/cdb_arbiter_if.sv | 48 ++++
 rtl/cdb_arbiter_rr.sv | 40 ++++
 rtl/cdb_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_pkg
//  Brief    : Shared widths, requester indices and urgency defaults for the
//             common-data-bus arbiter slice.
//  Revision : 1.0  initial release
// ============================================================================
package cdb_arbiter_pkg;

  // Default geometry of the CDB and its producers
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TAG_W   = 6;

  // Only the mult pipeline is unable to stall by default
  localparam logic [DEF_NUM_REQ-1:0] DEF_URGENT_MASK = 4'b0010;

  // Requester slot assignment on the arbiter inputs
  typedef enum logic [1:0] {
    REQ_INT  = 2'd0,
    REQ_MULT = 2'd1,
    REQ_DIV  = 2'd2,
    REQ_LDST = 2'd3
  } req_id_e;

endpackage : cdb_arbiter_pkg
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_if
//  Brief    : Requester handshake and CDB broadcast bundle. The master side
//             is the collection of execution units, the slave side is the
//             arbiter that owns the bus.
//  Revision : 1.0  initial release
// ============================================================================
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TAG_W   = DEF_TAG_W
);

  // Requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0]        req_branch;
  logic [NUM_REQ-1:0]        req_branch_taken;
  logic [NUM_REQ-1:0]        req_ready;

  // Broadcast side
  logic [DATA_W-1:0]         cdb_data;
  logic [TAG_W-1:0]          cdb_tag;
  logic                      cdb_valid;
  logic                      cdb_branch;
  logic                      cdb_branch_taken;
  logic                      urgent_conflict;

  modport master (
    output req_valid, req_data, req_tag, req_branch, req_branch_taken,
    input  req_ready,
    input  cdb_data, cdb_tag, cdb_valid, cdb_branch, cdb_branch_taken,
    input  urgent_conflict
  );

  modport slave (
    input  req_valid, req_data, req_tag, req_branch, req_branch_taken,
    output req_ready,
    output cdb_data, cdb_tag, cdb_valid, cdb_branch, cdb_branch_taken,
    output urgent_conflict
  );

endinterface : cdb_arbiter_if
`default_nettype wire

// File: rtl/cdb_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_rr
//  Brief    : Generic round-robin selector. Scans req starting at ptr and
//             wrapping modulo NUM_REQ; returns a one-hot grant, the encoded
//             winner and whether anything was found. Purely combinational,
//             the pointer lives in the caller. NUM_REQ must be at least 2.
//  Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter_rr
  import cdb_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // First requester at or after ptr, wrapping around the end
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int pos;
      pos = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
      end
    end
  end

endmodule : cdb_arbiter_rr
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Brief    : Common data bus arbiter. Urgent (non-stallable) producers win
//             outright, everyone else shares the bus round-robin. The grant
//             is combinational; the winning result is registered onto the
//             CDB one cycle later.
//  Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int                 NUM_REQ     = DEF_NUM_REQ,
  parameter int                 DATA_W      = DEF_DATA_W,
  parameter int                 TAG_W       = DEF_TAG_W,
  parameter logic [NUM_REQ-1:0] URGENT_MASK = NUM_REQ'(DEF_URGENT_MASK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  cdb_arbiter_if.slave     bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_idx;
  logic [NUM_REQ-1:0] rr_gnt;
  logic               rr_any;

  logic [NUM_REQ-1:0] urg_req;
  logic [IDX_W-1:0]   urg_idx;
  logic               urg_any;
  logic               urg_multi;

  logic               grant;
  logic               rr_win;
  logic [IDX_W-1:0]   win_idx;
  logic [DATA_W-1:0]  win_data;
  logic [TAG_W-1:0]   win_tag;
  logic               win_branch;
  logic               win_taken;

  assign urg_req = bus.req_valid & URGENT_MASK;

  cdb_arbiter_rr #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  // Lowest-index urgent requester and detection of simultaneous urgents
  always_comb begin
    urg_idx   = '0;
    urg_any   = 1'b0;
    urg_multi = ($countones(urg_req) > 1);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!urg_any && urg_req[k]) begin
        urg_any = 1'b1;
        urg_idx = IDX_W'(k);
      end
    end
  end

  // Winner selection with reset/flush gating; the one-hot rr_gnt is only
  // relevant when no urgent requester overrides it, so the encoded index
  // is used to build req_ready in both cases.
  always_comb begin
    grant         = !rst && !flush && (urg_any || rr_any);
    rr_win        = grant && !urg_any;
    win_idx       = urg_any ? urg_idx : rr_idx;
    bus.req_ready = '0;
    if (grant) begin
      bus.req_ready[win_idx] = 1'b1;
    end
  end

  // Field mux from the winning requester's slices
  assign win_data   = bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
  assign win_tag    = bus.req_tag[int'(win_idx)*TAG_W +: TAG_W];
  assign win_branch = bus.req_branch[win_idx];
  assign win_taken  = bus.req_branch_taken[win_idx];

  // CDB output register: load on grant, otherwise drop valid and flags but
  // keep data/tag so downstream tag comparators see a stable value
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cdb_valid        <= 1'b0;
      bus.cdb_branch       <= 1'b0;
      bus.cdb_branch_taken <= 1'b0;
      bus.cdb_data         <= '0;
      bus.cdb_tag          <= '0;
    end else if (grant) begin
      bus.cdb_valid        <= 1'b1;
      bus.cdb_branch       <= win_branch;
      bus.cdb_branch_taken <= win_taken;
      bus.cdb_data         <= win_data;
      bus.cdb_tag          <= win_tag;
    end else begin
      bus.cdb_valid        <= 1'b0;
      bus.cdb_branch       <= 1'b0;
      bus.cdb_branch_taken <= 1'b0;
    end
  end

  // Round-robin pointer moves past the winner only on a round-robin grant
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (rr_win) begin
      if (int'(rr_idx) == NUM_REQ - 1) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= rr_idx + 1'b1;
      end
    end
  end

  // One-cycle flag when more than one non-stallable unit collided
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.urgent_conflict <= 1'b0;
    end else begin
      bus.urgent_conflict <= urg_multi;
    end
  end

endmodule : cdb_arbiter
`default_nettype wire
